// File: rtl/vip_slave_mem.sv
// Memory-backed crossbar slave model: one outstanding transaction, programmable ack
// latency, byte-enabled writes, address decode error response and saturating counters.
module vip_slave_mem #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SLAVE_W  = 2,
    parameter int SLAVE_ID = 0,
    parameter int MEM_AW   = 8,
    parameter int LATENCY  = 0,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  slave_req,
    input  logic [ADDR_W-1:0]     slave_addr,
    input  logic                  slave_cmd,
    input  logic [DATA_W-1:0]     slave_wdata,
    input  logic [DATA_W/8-1:0]   slave_be,
    output logic                  slave_ack,
    output logic                  slave_err,
    output logic [DATA_W-1:0]     slave_rdata,
    output logic [CNT_W-1:0]      wr_cnt,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** MEM_AW;
    localparam int MID_W = ADDR_W - SLAVE_W - MEM_AW;
    localparam logic [3:0]       WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_capture;
    logic                    w_enter_ack;
    logic                    w_commit;
    logic                    w_txn_err;
    logic                    w_txn_cmd;
    logic [MEM_AW-1:0]       w_txn_idx;

    logic [3:0]              r_wait_cnt;
    logic [MEM_AW-1:0]       r_idx;
    logic                    r_cmd;
    logic                    r_dec_err;
    logic [DATA_W-1:0]       r_wdata;
    logic [BE_W-1:0]         r_be;

    logic                    r_ack;
    logic                    r_err_flag;
    logic [DATA_W-1:0]       r_rdata;
    logic [CNT_W-1:0]        r_wr_cnt;
    logic [CNT_W-1:0]        r_rd_cnt;
    logic [CNT_W-1:0]        r_err_cnt;

    logic [DATA_W-1:0]       r_mem [0:DEPTH-1];

    function automatic logic decode_err(input logic [ADDR_W-1:0] a);
        logic [SLAVE_W-1:0] sel;
        logic [MID_W-1:0]   mid;
        sel = a[ADDR_W-1 -: SLAVE_W];
        mid = a[ADDR_W-SLAVE_W-1:MEM_AW];
        return (sel != SLAVE_W'(SLAVE_ID)) || (mid != {MID_W{1'b0}});
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    // Next-state logic: IDLE captures a request, WAIT burns latency, ACK lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (slave_req) begin
                    w_capture = 1'b1;
                    if (LATENCY > 0) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_ACK;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With zero latency the ack is formed on the capture edge, so use live inputs in IDLE.
    always_comb begin
        w_txn_err = r_dec_err;
        w_txn_cmd = r_cmd;
        w_txn_idx = r_idx;
        if (r_state == S_IDLE) begin
            w_txn_err = decode_err(slave_addr);
            w_txn_cmd = slave_cmd;
            w_txn_idx = slave_addr[MEM_AW-1:0];
        end else begin
            w_txn_err = r_dec_err;
            w_txn_cmd = r_cmd;
            w_txn_idx = r_idx;
        end
    end

    assign w_enter_ack = (r_state != S_ACK) && (w_state_nxt == S_ACK);
    assign w_commit    = (r_state == S_ACK) && r_cmd && !r_dec_err;

    // State register and latency down-counter.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
        end
    end

    // Request capture; later input changes are ignored until the next IDLE.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx     <= {MEM_AW{1'b0}};
            r_cmd     <= 1'b0;
            r_dec_err <= 1'b0;
            r_wdata   <= {DATA_W{1'b0}};
            r_be      <= {BE_W{1'b0}};
        end else if (w_capture) begin
            r_idx     <= slave_addr[MEM_AW-1:0];
            r_cmd     <= slave_cmd;
            r_dec_err <= decode_err(slave_addr);
            r_wdata   <= slave_wdata;
            r_be      <= slave_be;
        end else begin
            r_idx     <= r_idx;
            r_cmd     <= r_cmd;
            r_dec_err <= r_dec_err;
            r_wdata   <= r_wdata;
            r_be      <= r_be;
        end
    end

    // Response outputs and statistics, all updated on the edge that enters ACK.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_ack      <= 1'b0;
            r_err_flag <= 1'b0;
            r_rdata    <= {DATA_W{1'b0}};
            r_wr_cnt   <= {CNT_W{1'b0}};
            r_rd_cnt   <= {CNT_W{1'b0}};
            r_err_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_ack      <= w_enter_ack;
            r_err_flag <= w_enter_ack && w_txn_err;
            if (w_enter_ack && !w_txn_err && !w_txn_cmd) begin
                r_rdata <= r_mem[w_txn_idx];
            end else begin
                r_rdata <= {DATA_W{1'b0}};
            end
            if (w_enter_ack) begin
                if (w_txn_err) begin
                    r_err_cnt <= sat_inc(r_err_cnt);
                end else if (w_txn_cmd) begin
                    r_wr_cnt <= sat_inc(r_wr_cnt);
                end else begin
                    r_rd_cnt <= sat_inc(r_rd_cnt);
                end
            end else begin
                r_err_cnt <= r_err_cnt;
                r_wr_cnt  <= r_wr_cnt;
                r_rd_cnt  <= r_rd_cnt;
            end
        end
    end

    // Write commit on the edge leaving ACK; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < BE_W; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign slave_ack   = r_ack;
    assign slave_err   = r_err_flag;
    assign slave_rdata = r_rdata;
    assign wr_cnt      = r_wr_cnt;
    assign rd_cnt      = r_rd_cnt;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vip_slave_mem.sv
// Bench for vip_slave_mem: three instances (latency 0/3/5) checked against a
// word-array reference model with saturating counters.
module tb_vip_slave_mem;

    localparam int NI = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn [NI];
    logic        req     [NI];
    logic [31:0] addr    [NI];
    logic        cmd     [NI];
    logic [31:0] wdata   [NI];
    logic [3:0]  be      [NI];
    logic        ack     [NI];
    logic        err     [NI];
    logic [31:0] rdata   [NI];
    logic [3:0]  wrc     [NI];
    logic [3:0]  rdc     [NI];
    logic [3:0]  erc     [NI];

    vip_slave_mem #(.SLAVE_ID(1), .LATENCY(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .aresetn(aresetn[0]), .slave_req(req[0]), .slave_addr(addr[0]),
        .slave_cmd(cmd[0]), .slave_wdata(wdata[0]), .slave_be(be[0]), .slave_ack(ack[0]),
        .slave_err(err[0]), .slave_rdata(rdata[0]), .wr_cnt(wrc[0]), .rd_cnt(rdc[0]),
        .err_cnt(erc[0]));
    vip_slave_mem #(.SLAVE_ID(0), .LATENCY(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .aresetn(aresetn[1]), .slave_req(req[1]), .slave_addr(addr[1]),
        .slave_cmd(cmd[1]), .slave_wdata(wdata[1]), .slave_be(be[1]), .slave_ack(ack[1]),
        .slave_err(err[1]), .slave_rdata(rdata[1]), .wr_cnt(wrc[1]), .rd_cnt(rdc[1]),
        .err_cnt(erc[1]));
    vip_slave_mem #(.SLAVE_ID(2), .LATENCY(5), .CNT_W(4)) u_dut2 (
        .clk(clk), .aresetn(aresetn[2]), .slave_req(req[2]), .slave_addr(addr[2]),
        .slave_cmd(cmd[2]), .slave_wdata(wdata[2]), .slave_be(be[2]), .slave_ack(ack[2]),
        .slave_err(err[2]), .slave_rdata(rdata[2]), .wr_cnt(wrc[2]), .rd_cnt(rdc[2]),
        .err_cnt(erc[2]));

    int          lat_of [NI] = '{0, 3, 5};
    int          id_of  [NI] = '{1, 0, 2};
    logic [31:0] m_mem   [NI][256];
    bit          m_known [NI][256];
    int          m_wr [NI];
    int          m_rd [NI];
    int          m_er [NI];
    bit          in_ack [NI];
    int          total = 0;
    int          bad   = 0;

    function automatic bit model_err(int k, logic [31:0] a);
        return ((a >> 30) != 32'(id_of[k])) || ((a % 32'h4000_0000) >= 32'd256);
    endfunction

    function automatic int sat(int c);
        return (c >= 15) ? 15 : c + 1;
    endfunction

    function automatic logic [31:0] base_of(int k);
        return 32'(id_of[k]) << 30;
    endfunction

    // One transaction: drive, wait for ack within a bound, check against the model.
    task automatic txn(int k, bit c, logic [31:0] a, logic [31:0] d, logic [3:0] b, string tag);
        int n, exp_n, idx;
        bit e, got;
        logic [31:0] exp_rd;
        exp_n = lat_of[k] + (in_ack[k] ? 2 : 1);
        req[k] = 1'b1; addr[k] = a; cmd[k] = c; wdata[k] = d; be[k] = b;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (ack[k] === 1'b1) begin
                got = 1'b1;
            end else begin
                total++;
                if (rdata[k] !== 32'd0 || err[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s quiet_out: rdata=%h err=%b, need 0/0", tag, rdata[k], err[k]);
                end
            end
        end
        total++;
        if (!got || n != exp_n) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles (ack=%0b), need %0d", tag, n, got, exp_n);
        end
        if (got) begin
            e   = model_err(k, a);
            idx = int'(a % 32'd256);
            exp_rd = 32'd0;
            if (!e && !c) exp_rd = m_mem[k][idx];
            if (e) m_er[k] = sat(m_er[k]);
            else if (c) m_wr[k] = sat(m_wr[k]);
            else m_rd[k] = sat(m_rd[k]);
            total++;
            if (err[k] !== e) begin
                bad++;
                $display("FAIL %s err: got %b need %b", tag, err[k], e);
            end
            if (e || c || m_known[k][idx]) begin
                total++;
                if (rdata[k] !== exp_rd) begin
                    bad++;
                    $display("FAIL %s rdata: got %h need %h", tag, rdata[k], exp_rd);
                end
            end
            total++;
            if (wrc[k] !== 4'(m_wr[k]) || rdc[k] !== 4'(m_rd[k]) || erc[k] !== 4'(m_er[k])) begin
                bad++;
                $display("FAIL %s counters: got wr=%0d rd=%0d er=%0d need %0d %0d %0d",
                         tag, wrc[k], rdc[k], erc[k], m_wr[k], m_rd[k], m_er[k]);
            end
            if (!e && c) begin
                if (b == 4'hF) m_known[k][idx] = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (b[i]) m_mem[k][idx][8*i +: 8] = d[8*i +: 8];
            end
        end
        in_ack[k] = got;
    endtask

    task automatic drop(int k);
        req[k] = 1'b0;
        @(posedge clk); #1;
        in_ack[k] = 1'b0;
        total++;
        if (ack[k] !== 1'b0) begin
            bad++;
            $display("FAIL drop%0d ack_pulse: ack=%b need 0", k, ack[k]);
        end
    endtask

    task automatic do_reset(int k);
        req[k] = 1'b0;
        aresetn[k] = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ack[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'd0 ||
            wrc[k] !== 4'd0 || rdc[k] !== 4'd0 || erc[k] !== 4'd0) begin
            bad++;
            $display("FAIL reset%0d outputs: ack=%b err=%b rdata=%h cnt=%0d/%0d/%0d need all 0",
                     k, ack[k], err[k], rdata[k], wrc[k], rdc[k], erc[k]);
        end
        @(negedge clk);
        aresetn[k] = 1'b1;
        m_wr[k] = 0; m_rd[k] = 0; m_er[k] = 0;
        in_ack[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            aresetn[k] = 1'b0; req[k] = 1'b0; addr[k] = 32'd0; cmd[k] = 1'b0;
            wdata[k] = 32'd0; be[k] = 4'd0; in_ack[k] = 1'b0;
            m_wr[k] = 0; m_rd[k] = 0; m_er[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            total++;
            if (ack[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'd0 ||
                wrc[k] !== 4'd0 || rdc[k] !== 4'd0 || erc[k] !== 4'd0) begin
                bad++;
                $display("FAIL init_reset%0d: ack=%b err=%b rdata=%h need 0", k, ack[k], err[k], rdata[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) aresetn[k] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_reset(0);
        txn(0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, "basic_wr");
        drop(0);
        txn(0, 1'b0, 32'h4000_0010, 32'd0, 4'h0, "basic_rd");
        total++;
        if (rdata[0] !== 32'hDEAD_BEEF || wrc[0] !== 4'd1 || rdc[0] !== 4'd1) begin
            bad++;
            $display("FAIL basic_const: rdata=%h wr=%0d rd=%0d need deadbeef 1 1", rdata[0], wrc[0], rdc[0]);
        end
        drop(0);
    endtask

    task automatic test_byte_enables();
        do_reset(1);
        txn(1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, "be_wr_full");
        drop(1);
        txn(1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, "be_wr_part");
        drop(1);
        txn(1, 1'b0, 32'h0000_0020, 32'd0, 4'h0, "be_rd");
        total++;
        if (rdata[1] !== 32'h11BB_33DD) begin
            bad++;
            $display("FAIL be_const: rdata=%h need 11bb33dd", rdata[1]);
        end
        drop(1);
        txn(1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, "be_zero");
        drop(1);
    endtask

    task automatic test_decode_error();
        do_reset(0);
        txn(0, 1'b1, 32'h8000_0010, 32'h5555_5555, 4'hF, "dec_sel");
        drop(0);
        txn(0, 1'b1, 32'h4000_0110, 32'h6666_6666, 4'hF, "dec_mid");
        drop(0);
        txn(0, 1'b0, 32'h4000_0010, 32'd0, 4'h0, "dec_reread");
        total++;
        if (rdata[0] !== 32'hDEAD_BEEF || erc[0] !== 4'd2) begin
            bad++;
            $display("FAIL dec_const: rdata=%h err_cnt=%0d need deadbeef 2", rdata[0], erc[0]);
        end
        drop(0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            txn(0, 1'b1, 32'h4000_0040 + 32'(i), $urandom, 4'hF, "b2b_fill");
        drop(0);
        do_reset(0);
        for (int i = 0; i < 8; i++)
            txn(0, 1'b0, 32'h4000_0040 + 32'(i), 32'd0, 4'h0, "b2b_rd");
        total++;
        if (rdc[0] !== 4'd8) begin
            bad++;
            $display("FAIL b2b_count: rd_cnt=%0d need 8", rdc[0]);
        end
        drop(0);
    endtask

    task automatic test_reset_abort();
        do_reset(2);
        txn(2, 1'b1, 32'h8000_0033, 32'h0BAD_F00D, 4'hF, "abort_old");
        drop(2);
        req[2] = 1'b1; addr[2] = 32'h8000_0033; cmd[2] = 1'b1;
        wdata[2] = 32'h1234_5678; be[2] = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        aresetn[2] = 1'b0;
        req[2] = 1'b0;
        #1;
        total++;
        if (ack[2] !== 1'b0 || wrc[2] !== 4'd0 || rdc[2] !== 4'd0 || erc[2] !== 4'd0) begin
            bad++;
            $display("FAIL abort_in_reset: ack=%b cnt=%0d/%0d/%0d need 0", ack[2], wrc[2], rdc[2], erc[2]);
        end
        @(negedge clk);
        aresetn[2] = 1'b1;
        m_wr[2] = 0; m_rd[2] = 0; m_er[2] = 0; in_ack[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            total++;
            if (ack[2] !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_ack: ack=1 at cycle %0d need 0", i);
            end
        end
        txn(2, 1'b0, 32'h8000_0033, 32'd0, 4'h0, "abort_reread");
        total++;
        if (rdata[2] !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL abort_const: rdata=%h need 0badf00d", rdata[2]);
        end
        drop(2);
    endtask

    task automatic test_saturation();
        do_reset(0);
        for (int i = 0; i < 17; i++)
            txn(0, 1'b1, 32'h4000_0080 + 32'(i), $urandom, 4'($urandom_range(0, 15)), "sat_wr");
        total++;
        if (wrc[0] !== 4'hF || rdc[0] !== 4'd0 || erc[0] !== 4'd0) begin
            bad++;
            $display("FAIL sat_const: wr=%0d rd=%0d er=%0d need 15 0 0", wrc[0], rdc[0], erc[0]);
        end
        drop(0);
    endtask

    task automatic test_random();
        int k, prev;
        logic [31:0] a;
        prev = -1;
        for (int it = 0; it < 80; it++) begin
            k = $urandom_range(0, NI - 1);
            if (prev >= 0 && (prev != k || $urandom_range(0, 1) == 0)) drop(prev);
            a = base_of(k) | 32'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: a = a ^ 32'h4000_0000;
                1: a = a | (32'd1 << $urandom_range(8, 29));
                default: a = a;
            endcase
            txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand");
            prev = k;
        end
        if (prev >= 0) drop(prev);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enables();
        test_decode_error();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
